// File: rtl/vga24_pkg.sv
// Shared widths, field offsets and the beat record for the RGB888 -> 24-bit video packer.
package vga24_pkg;

  localparam int PIX_W   = 24;
  localparam int COMP_W  = 8;
  localparam int R_MSB   = 23;
  localparam int G_MSB   = 15;
  localparam int B_MSB   = 7;
  localparam int COORD_W = 12;

  typedef struct packed {
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;
    logic              sof;
    logic              eol;
  } vga24_beat_t;

  // Pure bit placement of the three components into one video word.
  function automatic logic [PIX_W-1:0] pack_rgb(input vga24_beat_t beat);
    logic [PIX_W-1:0] word;
    word = '0;
    word[R_MSB -: COMP_W] = beat.r;
    word[G_MSB -: COMP_W] = beat.g;
    word[B_MSB -: COMP_W] = beat.b;
    return word;
  endfunction

endpackage

// File: rtl/vga24_skid_buf.sv
// Generic 2-entry skid buffer: an output register plus one holding register.
// s_ready is registered and only reflects whether the holding register is empty.
module vga24_skid_buf #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         skid_valid_nxt;
  logic         accept;
  logic         load;

  assign accept = s_valid & s_ready;
  assign load   = ~m_valid | m_ready;

  always_comb begin
    skid_valid_nxt = skid_valid;
    if (load)
      skid_valid_nxt = 1'b0;
    else if (accept)
      skid_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      s_ready    <= 1'b0;
    end else begin
      skid_valid <= skid_valid_nxt;
      s_ready    <= ~skid_valid_nxt;
      // s_ready is low whenever the skid holds data, so accept and skid_valid never coincide.
      if (load) begin
        if (skid_valid) begin
          m_data  <= skid_data;
          m_valid <= 1'b1;
        end else begin
          m_valid <= accept;
          if (accept)
            m_data <= s_data;
        end
      end else if (accept) begin
        skid_data <= s_data;
      end
    end
  end

endmodule

// File: rtl/rgb888_to_vga24.sv
// Packs R/G/B + sof/eol into 24-bit video words, tracks pixel coordinates.
// Optional geometry checker enabled by defining RGB888_GEOM_CHECK_EN.
module rgb888_to_vga24
  import vga24_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COMP_W-1:0]  s_r,
  input  logic [COMP_W-1:0]  s_g,
  input  logic [COMP_W-1:0]  s_b,
  input  logic               s_sof,
  input  logic               s_eol,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [PIX_W-1:0]   m_data,
  output logic               m_sof,
  output logic               m_eol,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  input  logic               err_clr,
  output logic               err_line,
  output logic               err_frame
);

  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

  vga24_beat_t        in_beat;
  vga24_beat_t        out_beat;
  logic               xfer;
  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;

  assign in_beat = '{r: s_r, g: s_g, b: s_b, sof: s_sof, eol: s_eol};

  vga24_skid_buf #(
    .W($bits(vga24_beat_t))
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  (in_beat),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (out_beat),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  assign m_data = pack_rgb(out_beat);
  assign m_sof  = out_beat.sof;
  assign m_eol  = out_beat.eol;
  assign xfer   = m_valid & m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (xfer) begin
      if (m_eol) begin
        x_cnt <= '0;
        y_cnt <= m_sof ? '0 : y_cnt + COORD_ONE;
      end else begin
        x_cnt <= (m_sof ? '0 : x_cnt) + COORD_ONE;
        if (m_sof)
          y_cnt <= '0;
      end
    end
  end

  assign pix_x = m_sof ? '0 : x_cnt;
  assign pix_y = m_sof ? '0 : y_cnt;

`ifdef RGB888_GEOM_CHECK_EN
  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_LINES = COORD_W'(V_ACTIVE);

  logic seen_sof;

  // A new error in the same cycle as err_clr must survive, so sets come last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_line  <= 1'b0;
      err_frame <= 1'b0;
      seen_sof  <= 1'b0;
    end else begin
      if (err_clr) begin
        err_line  <= 1'b0;
        err_frame <= 1'b0;
      end
      if (xfer && m_eol && (pix_x != H_LAST))
        err_line <= 1'b1;
      if (xfer && m_sof && seen_sof && (y_cnt != V_LINES))
        err_frame <= 1'b1;
      if (xfer && m_sof)
        seen_sof <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = err_clr ^ (H_ACTIVE == V_ACTIVE);
  assign err_line   = 1'b0;
  assign err_frame  = 1'b0;
`endif

endmodule
